tluh_device_adapter: RTL
========================

Name: tluh_device_adapter

Overview:
- Device-side (responder) end of the TL-UH link.
- Accepts one TL-UH channel A request at a time and drives a simple req/gnt/rvalid memory-style port toward a peripheral or SRAM.
- Returns exactly one single-beat channel D response per request.
- Executes ArithmeticData/LogicalData atomics locally as read-modify-write; Intent is acknowledged without device access.

Parameters:
- ATOMIC_EN, 1, 1 executes Arithmetic/Logical as RMW; 0 answers them with d_error=1 and no device access.
- ADDR_W, tluh_pkg::TL_AW, width of dev_addr_o.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- tl_d_i  in  tluh_pkg::tluh_h2d_t  channel A request plus d_ready.
- tl_d_o  out  tluh_pkg::tluh_d2h_t  channel D response plus a_ready.
- dev_req_o  out  1  device request; held until granted.
- dev_gnt_i  in  1  device accepts the request this cycle.
- dev_we_o  out  1  1=write, 0=read.
- dev_addr_o  out  ADDR_W  word-aligned address.
- dev_wdata_o  out  TL_DW  write data.
- dev_be_o  out  TL_DBW  byte enables (all ones for reads).
- dev_rvalid_i  in  1  completion, one per granted request, for reads and writes.
- dev_rdata_i  in  TL_DW  read data, valid with dev_rvalid_i.
- dev_err_i  in  1  device error, valid with dev_rvalid_i.

Behaviour:
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP.
- Reset: state=IDLE; all tl_d_o fields 0 except a_ready=1; dev_req_o=0, dev_we_o=0, dev_addr_o=0, dev_wdata_o=0, dev_be_o=0. Reset mid-transaction drops it silently, with no response.
- a_ready=1 only in IDLE. On a_valid&a_ready, latch opcode, param, size, source, address, mask, data. Exactly one outstanding request.
- Decode in IDLE at accept:
  - Error (-> RESP, d_error=1, d_data=0, no device access) when any of these holds:
    - a_size != log2(TL_DBW);
    - address low bits nonzero;
    - Get with mask != all ones;
    - atomic with mask != all ones;
    - atomic with ATOMIC_EN=0;
    - illegal param (arith > 4, logic > 3);
    - unknown opcode.
  - Get -> RD_REQ.
  - PutFullData/PutPartialData -> WR_REQ, with dev_be_o=a_mask.
  - Arith/Logical -> RD_REQ.
  - Intent -> RESP, d_opcode=HintAck.
- RD_REQ/WR_REQ:
  - dev_req_o=1 with stable addr/we/wdata/be until dev_gnt_i.
  - On grant -> RD_WAIT/WR_WAIT; dev_req_o deasserts the next cycle.
- RD_WAIT on dev_rvalid_i:
  - Register old=dev_rdata_i.
  - Get -> RESP.
  - Atomic with dev_err_i=1 -> RESP with d_error=1 and no write.
  - Otherwise compute new and go to WR_REQ with dev_be_o all ones.
- Atomic arithmetic on the full TL_DW word:
  - MIN=signed min(old,a_data); MAX=signed max; MINU, MAXU unsigned; ADD=old+a_data, modulo 2^TL_DW, carry dropped.
  - XOR, OR, AND bitwise; SWAP=a_data.
- WR_WAIT on dev_rvalid_i -> RESP; d_error is the OR of the read-phase and write-phase errors.
- RESP:
  - d_valid=1, registered, first asserted the cycle after the completing dev_rvalid_i, or the cycle after accept for error/Intent.
  - d_source and d_size echo the request; d_param=0.
  - d_opcode: AccessAckData for Get/Arith/Logical, AccessAck for Puts, HintAck for Intent.
  - d_data: rdata for Get, old for atomics, 0 otherwise. For an errored Get, d_data is 0.
  - All D fields held stable until d_ready. d_valid&d_ready -> IDLE.
  - a_ready rises the cycle after the handshake, so back-to-back throughput is one request per 2 cycles plus device latency.
- A dev_rvalid_i arriving outside RD_WAIT/WR_WAIT is ignored.
- Best-case latency, with gnt in the same cycle as req and rvalid one cycle after gnt:
  - Get/Put: accept at T, dev_req_o at T+1, rvalid at T+2, d_valid at T+3.
  - Atomic: d_valid at T+5.

Test Plan:
- Get at addr 0x10, source 2, device returns 0xDEADBEEF at T+2 -> d_valid at T+3, AccessAckData, d_data=0xDEADBEEF, d_source=2, d_error=0.
- PutPartialData at addr 0x20, mask 4'b0011, data 0x12345678 -> dev_we_o=1, dev_be_o=0011, AccessAck with d_data=0. Hold d_ready=0 for 5 cycles -> D fields stable and a_ready=0 throughout.
- ArithmeticData ADD, memory word 0xFFFFFFFF, a_data 2 -> write 0x00000001, response d_data=0xFFFFFFFF. Repeat with MIN signed, old 0x80000000 vs 5 -> writes 0x80000000.
- LogicalData SWAP, old 0xA5A5A5A5, data 0x5A5A5A5A -> dev write 0x5A5A5A5A, d_data=0xA5A5A5A5. Same op with dev_err_i on the read -> no write request, d_error=1.
- Get with a_size=1 or address 0x3 -> no dev_req_o, error response next cycle. Intent -> HintAck with no dev_req_o.
- dev_gnt_i held low for 4 cycles then reset pulsed -> dev_req_o=0, a_ready=1 after reset, no d_valid.

Source files
------------

// File: rtl/tluh_device_adapter.sv
// tluh_pkg: TL-UH widths, opcode/param encodings and the channel structs.
// tluh_device_adapter: device-side TL-UH responder. Accepts one channel A
// request at a time, drives a req/gnt/rvalid memory port, performs
// Arithmetic/Logical atomics as read-modify-write and returns one
// single-beat channel D response per request.
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   tl_d_i / tl_d_o        channel A (+d_ready) in, channel D (+a_ready) out
//   dev_req_o/dev_gnt_i    device request held until granted
//   dev_we_o, dev_addr_o   write enable, word-aligned address
//   dev_wdata_o, dev_be_o  write data, byte enables (all ones for reads)
//   dev_rvalid_i           one completion per granted request
//   dev_rdata_i, dev_err_i read data and error, valid with dev_rvalid_i

package tluh_pkg;
  localparam int unsigned TL_AW  = 32;
  localparam int unsigned TL_DW  = 32;
  localparam int unsigned TL_DBW = TL_DW / 8;
  localparam int unsigned TL_SZW = 2;
  localparam int unsigned TL_AIW = 8;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    ArithmeticData = 3'h2,
    LogicalData    = 3'h3,
    Get            = 3'h4,
    Intent         = 3'h5
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1,
    HintAck       = 3'h2
  } tl_d_op_e;

  typedef enum logic [2:0] {
    ArithMin  = 3'h0,
    ArithMax  = 3'h1,
    ArithMinu = 3'h2,
    ArithMaxu = 3'h3,
    ArithAdd  = 3'h4
  } tl_arith_e;

  typedef enum logic [2:0] {
    LogicXor  = 3'h0,
    LogicOr   = 3'h1,
    LogicAnd  = 3'h2,
    LogicSwap = 3'h3
  } tl_logic_e;

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tluh_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tluh_d2h_t;
endpackage

module tluh_device_adapter
  import tluh_pkg::*;
#(
  parameter bit          ATOMIC_EN = 1'b1,
  parameter int unsigned ADDR_W    = TL_AW
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  tluh_pkg::tluh_h2d_t          tl_d_i,
  output tluh_pkg::tluh_d2h_t          tl_d_o,
  output logic                         dev_req_o,
  input  logic                         dev_gnt_i,
  output logic                         dev_we_o,
  output logic [ADDR_W-1:0]            dev_addr_o,
  output logic [tluh_pkg::TL_DW-1:0]   dev_wdata_o,
  output logic [tluh_pkg::TL_DBW-1:0]  dev_be_o,
  input  logic                         dev_rvalid_i,
  input  logic [tluh_pkg::TL_DW-1:0]   dev_rdata_i,
  input  logic                         dev_err_i
);

  localparam int unsigned       ALIGN_W = $clog2(TL_DBW);
  localparam logic [TL_SZW-1:0] SZ_WORD = TL_SZW'(ALIGN_W);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    RESP
  } state_e;

  state_e r_state;
  state_e w_state_nxt;

  logic [2:0]        r_opcode;
  logic [2:0]        r_param;
  logic [TL_SZW-1:0] r_size;
  logic [TL_AIW-1:0] r_source;
  logic [ADDR_W-1:0] r_addr;
  logic [TL_DW-1:0]  r_adata;
  logic [TL_DW-1:0]  r_wdata;
  logic [TL_DBW-1:0] r_be;
  logic              r_rd_err;
  logic [2:0]        r_d_opcode;
  logic [TL_DW-1:0]  r_d_data;
  logic              r_d_error;

  logic             w_accept;
  logic             w_is_get;
  logic             w_is_put;
  logic             w_is_atomic;
  logic             w_is_intent;
  logic             w_mask_full;
  logic             w_param_bad;
  logic             w_dec_err;
  logic [2:0]       w_d_opcode;
  logic             w_r_is_get;
  logic [TL_DW-1:0] w_amo_new;

  // Channel A decode, evaluated on the live request while in IDLE.
  always_comb begin
    w_accept    = tl_d_i.a_valid && (r_state == IDLE);
    w_is_get    = (tl_d_i.a_opcode == Get);
    w_is_put    = (tl_d_i.a_opcode == PutFullData) || (tl_d_i.a_opcode == PutPartialData);
    w_is_atomic = (tl_d_i.a_opcode == ArithmeticData) || (tl_d_i.a_opcode == LogicalData);
    w_is_intent = (tl_d_i.a_opcode == Intent);
    w_mask_full = &tl_d_i.a_mask;
    w_param_bad = ((tl_d_i.a_opcode == ArithmeticData) && (tl_d_i.a_param > 3'(ArithAdd))) ||
                  ((tl_d_i.a_opcode == LogicalData)    && (tl_d_i.a_param > 3'(LogicSwap)));
    w_dec_err   = (tl_d_i.a_size != SZ_WORD)
               || (|tl_d_i.a_address[ALIGN_W-1:0])
               || (w_is_get && !w_mask_full)
               || (w_is_atomic && !w_mask_full)
               || (w_is_atomic && !ATOMIC_EN)
               || w_param_bad
               || !(w_is_get || w_is_put || w_is_atomic || w_is_intent);
    if (w_is_intent) begin
      w_d_opcode = HintAck;
    end else if (w_is_get || w_is_atomic) begin
      w_d_opcode = AccessAckData;
    end else begin
      w_d_opcode = AccessAck;
    end
  end

  assign w_r_is_get = (r_opcode == Get);

  // New memory value for the write phase of an atomic; old value is dev_rdata_i.
  always_comb begin
    w_amo_new = r_adata;
    if (r_opcode == ArithmeticData) begin
      case (r_param)
        ArithMin:  w_amo_new = ($signed(dev_rdata_i) < $signed(r_adata)) ? dev_rdata_i : r_adata;
        ArithMax:  w_amo_new = ($signed(dev_rdata_i) > $signed(r_adata)) ? dev_rdata_i : r_adata;
        ArithMinu: w_amo_new = (dev_rdata_i < r_adata) ? dev_rdata_i : r_adata;
        ArithMaxu: w_amo_new = (dev_rdata_i > r_adata) ? dev_rdata_i : r_adata;
        default:   w_amo_new = dev_rdata_i + r_adata;
      endcase
    end else begin
      case (r_param)
        LogicXor: w_amo_new = dev_rdata_i ^ r_adata;
        LogicOr:  w_amo_new = dev_rdata_i | r_adata;
        LogicAnd: w_amo_new = dev_rdata_i & r_adata;
        default:  w_amo_new = r_adata;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_dec_err || w_is_intent) begin
            w_state_nxt = RESP;
          end else if (w_is_put) begin
            w_state_nxt = WR_REQ;
          end else begin
            w_state_nxt = RD_REQ;
          end
        end
      end
      RD_REQ:  if (dev_gnt_i) w_state_nxt = RD_WAIT;
      WR_REQ:  if (dev_gnt_i) w_state_nxt = WR_WAIT;
      RD_WAIT: begin
        if (dev_rvalid_i) begin
          w_state_nxt = (w_r_is_get || dev_err_i) ? RESP : WR_REQ;
        end
      end
      WR_WAIT: if (dev_rvalid_i) w_state_nxt = RESP;
      RESP:    if (tl_d_i.d_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_opcode   <= '0;
      r_param    <= '0;
      r_size     <= '0;
      r_source   <= '0;
      r_addr     <= '0;
      r_adata    <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_rd_err   <= 1'b0;
      r_d_opcode <= '0;
      r_d_data   <= '0;
      r_d_error  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_opcode   <= tl_d_i.a_opcode;
            r_param    <= tl_d_i.a_param;
            r_size     <= tl_d_i.a_size;
            r_source   <= tl_d_i.a_source;
            r_addr     <= {tl_d_i.a_address[ADDR_W-1:ALIGN_W], {ALIGN_W{1'b0}}};
            r_adata    <= tl_d_i.a_data;
            r_wdata    <= tl_d_i.a_data;
            r_be       <= w_is_put ? tl_d_i.a_mask : '1;
            r_rd_err   <= 1'b0;
            r_d_opcode <= w_d_opcode;
            r_d_data   <= '0;
            r_d_error  <= w_dec_err;
          end
        end
        RD_WAIT: begin
          if (dev_rvalid_i) begin
            r_rd_err  <= dev_err_i;
            r_d_error <= dev_err_i;
            r_d_data  <= dev_err_i ? '0 : dev_rdata_i;
            if (!w_r_is_get && !dev_err_i) begin
              r_wdata <= w_amo_new;
              r_be    <= '1;
            end
          end
        end
        WR_WAIT: begin
          if (dev_rvalid_i) begin
            r_d_error <= r_rd_err | dev_err_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign dev_req_o   = (r_state == RD_REQ) || (r_state == WR_REQ);
  assign dev_we_o    = (r_state == WR_REQ);
  assign dev_addr_o  = r_addr;
  assign dev_wdata_o = r_wdata;
  assign dev_be_o    = r_be;

  always_comb begin
    tl_d_o          = '0;
    tl_d_o.a_ready  = (r_state == IDLE);
    tl_d_o.d_valid  = (r_state == RESP);
    tl_d_o.d_opcode = r_d_opcode;
    tl_d_o.d_param  = '0;
    tl_d_o.d_size   = r_size;
    tl_d_o.d_source = r_source;
    tl_d_o.d_data   = r_d_data;
    tl_d_o.d_error  = r_d_error;
  end

endmodule
